timebase_ctrl: RTL and testbench

Mode controller and tick scheduler for the clock's timebase. Replaces the free-running divided 1 Hz clock with single-cycle enables in the clk_50MHz domain. Supports RUN, PAUSE and SET modes, manual step and auto-repeat fast-set ticks, phase resync, and a blink enable for the display during time setting. Sits between the button/mode logic and the BCD time counters.

---
 rtl/timebase_pkg.sv | 21 ++
 rtl/timebase_ctrl_counter.sv | 50 +++++
 rtl/timebase_ctrl.sv | 128 ++++++++++++
 tb/tb_timebase_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase controller: mode encodings and
// cycle-count constants for the real 50 MHz board and for fast simulation.
package timebase_pkg;

  typedef enum logic [1:0] {
    MODE_PAUSE = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_SET   = 2'b10
  } mode_e;

  // Real-hardware timing at 50 MHz
  localparam int unsigned DEF_SEC_CYCLES  = 50_000_000;
  localparam int unsigned DEF_FAST_CYCLES = 6_250_000;
  localparam int unsigned DEF_BLINK_HALF  = 12_500_000;

  // Shortened timing so simulations see several periods quickly
  localparam int unsigned SIM_SEC   = 10;
  localparam int unsigned SIM_FAST  = 3;
  localparam int unsigned SIM_BLINK = 4;

endpackage

// File: rtl/timebase_ctrl_counter.sv
// Terminal-count counter used for the second, fast-repeat and blink timers.
// Counts 0..TERM-1 while enabled, holds while disabled, clears synchronously
// (clear beats counting). 'wrap' flags the edge on which the count rolls over;
// 'wrap_pulse' is that event registered, optionally qualified by pulse_en.
module tc_counter #(
  parameter int unsigned TERM  = 2,
  parameter int unsigned WIDTH = (TERM > 1) ? $clog2(TERM) : 1
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic pulse_en,
  output logic wrap,
  output logic wrap_pulse
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERM - 1);

  logic [WIDTH-1:0] count;

  generate
    if (TERM < 2) begin : g_bad_term
      $error("tc_counter: TERM must be at least 2");
    end
  endgenerate

  assign wrap = en && !clr && (count == LAST);

  // Count register: clear first, then roll over at the terminal value
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

  // One-cycle pulse in the cycle after a qualified rollover
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap && pulse_en;
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Timebase mode controller: turns the 50 MHz clock into single-cycle 1 Hz
// ticks in RUN, adjust ticks (manual step / auto-repeat) in PAUSE and SET,
// and a blink enable for the display while the time is being set.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned SEC_CYCLES  = DEF_SEC_CYCLES,
  parameter int unsigned FAST_CYCLES = DEF_FAST_CYCLES,
  parameter int unsigned BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       set_mode,
  input  logic       step_req,
  input  logic       fast_req,
  input  logic       sync_req,
  output logic       tick_1hz,
  output logic       tick_adj,
  output logic       blink,
  output logic [1:0] mode
);

  generate
    if (SEC_CYCLES < 2 || FAST_CYCLES < 2 || BLINK_HALF < 2) begin : g_bad_param
      $error("timebase_ctrl: all cycle parameters must be at least 2");
    end
  endgenerate

  mode_e state;
  mode_e next_state;

  logic sec_en, sec_clr, sec_tick_ok;
  logic fast_en, fast_clr, fast_wrap;
  logic blink_en, blink_clr, blink_wrap;
  logic step_ok;
  logic unused_sec_wrap, unused_fast_pulse, unused_blink_pulse;

  // Mode register; the mode output is this state directly
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= MODE_PAUSE;
    end else begin
      state <= next_state;
    end
  end

  // Next mode from the request levels, plus timer controls for this edge
  always_comb begin
    next_state  = MODE_PAUSE;
    sec_en      = 1'b0;
    sec_clr     = 1'b0;
    sec_tick_ok = 1'b0;
    fast_en     = 1'b0;
    fast_clr    = 1'b1;
    blink_en    = 1'b0;
    blink_clr   = 1'b1;
    step_ok     = 1'b0;

    if (set_mode) begin
      next_state = MODE_SET;
    end else if (run_en) begin
      next_state = MODE_RUN;
    end

    sec_en      = (state == MODE_RUN);
    sec_clr     = sync_req || ((state == MODE_SET) && (next_state != MODE_SET));
    sec_tick_ok = (next_state == MODE_RUN);
    fast_en     = (state == MODE_SET) && fast_req;
    fast_clr    = !fast_en;
    blink_en    = (state == MODE_SET);
    blink_clr   = (next_state != MODE_SET);
    step_ok     = step_req && (state != MODE_RUN);
  end

  tc_counter #(.TERM(SEC_CYCLES)) u_sec (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .en         (sec_en),
    .clr        (sec_clr),
    .pulse_en   (sec_tick_ok),
    .wrap       (unused_sec_wrap),
    .wrap_pulse (tick_1hz)
  );

  tc_counter #(.TERM(FAST_CYCLES)) u_fast (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .en         (fast_en),
    .clr        (fast_clr),
    .pulse_en   (1'b1),
    .wrap       (fast_wrap),
    .wrap_pulse (unused_fast_pulse)
  );

  tc_counter #(.TERM(BLINK_HALF)) u_blink (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .en         (blink_en),
    .clr        (blink_clr),
    .pulse_en   (1'b0),
    .wrap       (blink_wrap),
    .wrap_pulse (unused_blink_pulse)
  );

  // Adjust tick: a step and a fast rollover on the same edge merge into one pulse
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      tick_adj <= 1'b0;
    end else begin
      tick_adj <= step_ok || fast_wrap;
    end
  end

  // Blink enable: forced on outside SET, toggles at each half-period inside SET
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b1;
    end else if (next_state != MODE_SET) begin
      blink <= 1'b1;
    end else if (blink_wrap) begin
      blink <= ~blink;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl with shortened timing constants.
// A behavioural model tracks elapsed RUN cycles, fast-hold time and time
// spent in SET, and derives the expected outputs from those ages.
module tb_timebase_ctrl;
  import timebase_pkg::*;

  localparam int SEC   = SIM_SEC;
  localparam int FAST  = SIM_FAST;
  localparam int BLINK = SIM_BLINK;

  logic       clk_50MHz = 1'b0;
  logic       rst_n     = 1'b1;
  logic       run_en    = 1'b0;
  logic       set_mode  = 1'b0;
  logic       step_req  = 1'b0;
  logic       fast_req  = 1'b0;
  logic       sync_req  = 1'b0;
  logic       tick_1hz;
  logic       tick_adj;
  logic       blink;
  logic [1:0] mode;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state: ages, not counter images
  int   m_mode;
  int   m_run_edges;
  int   m_fast_run;
  int   m_set_age;
  logic exp_tick1;
  logic exp_adj;
  logic exp_blink;

  timebase_ctrl #(
    .SEC_CYCLES  (SEC),
    .FAST_CYCLES (FAST),
    .BLINK_HALF  (BLINK)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .set_mode  (set_mode),
    .step_req  (step_req),
    .fast_req  (fast_req),
    .sync_req  (sync_req),
    .tick_1hz  (tick_1hz),
    .tick_adj  (tick_adj),
    .blink     (blink),
    .mode      (mode)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_mode"},  mode,            2'(m_mode));
    checkOutput({tag, "_tick1"}, {1'b0, tick_1hz}, {1'b0, exp_tick1});
    checkOutput({tag, "_adj"},   {1'b0, tick_adj}, {1'b0, exp_adj});
    checkOutput({tag, "_blink"}, {1'b0, blink},    {1'b0, exp_blink});
  endtask

  task automatic modelReset();
    m_mode      = 0;
    m_run_edges = 0;
    m_fast_run  = 0;
    m_set_age   = 0;
    exp_tick1   = 1'b0;
    exp_adj     = 1'b0;
    exp_blink   = 1'b1;
  endtask

  // One clock edge of the model, using the inputs presented for that edge
  task automatic modelStep();
    int nxt;
    bit fast_hit;
    nxt       = set_mode ? 2 : (run_en ? 1 : 0);
    exp_tick1 = 1'b0;
    fast_hit  = 1'b0;

    if (sync_req || (m_mode == 2 && nxt != 2)) begin
      m_run_edges = 0;
    end else if (m_mode == 1) begin
      m_run_edges++;
      if (m_run_edges % SEC == 0) exp_tick1 = (nxt == 1);
    end

    if (m_mode == 2 && fast_req) begin
      m_fast_run++;
      fast_hit = (m_fast_run % FAST == 0);
    end else begin
      m_fast_run = 0;
    end
    exp_adj = (step_req && m_mode != 1) || fast_hit;

    if (nxt == 2) begin
      m_set_age = (m_mode == 2) ? m_set_age + 1 : 0;
      exp_blink = ((m_set_age / BLINK) % 2) == 0;
    end else begin
      m_set_age = 0;
      exp_blink = 1'b1;
    end

    m_mode = nxt;
  endtask

  // Called just after a rising edge: drive inputs, clock once, compare
  task automatic applyStimulus(input logic r, input logic s, input logic st,
                               input logic f, input logic sy, input string tag);
    run_en   = r;
    set_mode = s;
    step_req = st;
    fast_req = f;
    sync_req = sy;
    @(posedge clk_50MHz);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  // Assert reset away from any edge and expect outputs to fall back at once
  task automatic doAsyncReset(input string tag);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_mode"},  mode,             2'd0);
    checkOutput({tag, "_tick1"}, {1'b0, tick_1hz}, 2'd0);
    checkOutput({tag, "_adj"},   {1'b0, tick_adj}, 2'd0);
    checkOutput({tag, "_blink"}, {1'b0, blink},    2'd1);
    modelReset();
    @(posedge clk_50MHz);
    #1;
    checkAll({tag, "_held"});
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    logic r_run, r_set, r_fast;

    modelReset();
    @(posedge clk_50MHz);
    #1;
    doAsyncReset("init");

    // Free run: ticks every SEC cycles, blink stays on
    for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 0, "run");

    // Pause keeps the second phase
    doAsyncReset("r2");
    for (int i = 0; i < 7; i++)  applyStimulus(1, 0, 0, 0, 0, "pre_pause");
    for (int i = 0; i < 5; i++)  applyStimulus(0, 0, 0, 0, 0, "pause");
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0, "resume");

    // SET with a manual step, blink pattern
    doAsyncReset("r3");
    for (int i = 0; i < 13; i++) applyStimulus(0, 1, (i == 3), 0, 0, "set_step");

    // Fast repeat with a step landing on the second rollover
    doAsyncReset("r4");
    for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, 0, "set_idle");
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, (i == 5), 1, 0, "fast");
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 0, 0, 0, "fast_off");

    // Phase resync at count 7 and at the wrap count 9
    doAsyncReset("r5");
    for (int i = 0; i < 8; i++)  applyStimulus(1, 0, 0, 0, 0, "run_a");
    applyStimulus(1, 0, 0, 0, 1, "sync7");
    for (int i = 0; i < 9; i++)  applyStimulus(1, 0, 0, 0, 0, "run_b");
    applyStimulus(1, 0, 0, 0, 1, "sync9");
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0, "run_c");

    // Reset in the middle of SET with fast held, then re-enter SET
    doAsyncReset("r6");
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 0, 1, 0, "set_fast");
    doAsyncReset("mid_set");
    for (int i = 0; i < 8; i++)  applyStimulus(0, 1, 0, 1, 0, "after_rst");

    // Random traffic with persistent mode levels and sparse pulses
    r_run  = 1'b0;
    r_set  = 1'b0;
    r_fast = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)  r_run  = ~r_run;
      if ($urandom_range(0, 14) == 0) r_set  = ~r_set;
      if ($urandom_range(0, 5) == 0)  r_fast = ~r_fast;
      applyStimulus(r_run, r_set, ($urandom_range(0, 7) == 0), r_fast,
                    ($urandom_range(0, 39) == 0), "rand");
      if (i % 200 == 199) doAsyncReset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
